// File: rtl/ysyx_22041412_wbu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041412_wbu_if
//  Purpose  : Bundles the write-back unit's handshake, register-file write
//             and scoreboard query signals.
//  Ports    : master = pipeline/testbench side, slave = write-back unit side.
//             iss_*  : long-latency op issue (sets scoreboard bit)
//             alu_*  : single-cycle result handshake
//             lsu_*  : long-latency result handshake
//             Rw/Wen/BusW : register-file write port
//             rs1/rs2/q_rd -> hazard, busy : scoreboard query / debug
//  Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22041412_wbu_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  Rw;
  logic        Wen;
  logic [63:0] BusW;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  q_rd;
  logic        hazard;
  logic [31:0] busy;

  modport master (
    output iss_valid, iss_rd,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  Rw, Wen, BusW,
    output rs1, rs2, q_rd,
    input  hazard, busy
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output Rw, Wen, BusW,
    input  rs1, rs2, q_rd,
    output hazard, busy
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041412_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041412_wbu
//  Purpose  : Write-back unit. Arbitrates between single-cycle ALU results and
//             queued long-latency results (long results have priority), drives
//             a registered register-file write port and tracks pending
//             long-latency destinations in a 32-bit scoreboard.
//  Ports    : clk  - clock, all state on posedge
//             rst  - synchronous active-high reset
//             bus  - ysyx_22041412_wbu_if.slave (handshakes, RF write, hazard)
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041412_wbu #(
  parameter int LONG_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22041412_wbu_if.slave        bus
);

  // LONG_DEPTH is a power of two >= 2, so pointers wrap naturally.
  localparam int              AW       = $clog2(LONG_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(LONG_DEPTH);

  logic [4:0]    fifo_rd_q   [LONG_DEPTH];
  logic [63:0]   fifo_data_q [LONG_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]    rw_q, rw_d;
  logic          wen_q, wen_d;
  logic [63:0]   busw_q, busw_d;
  logic          long_q, long_d;   // output stage holds a long result
  logic [31:0]   busy_q, busy_d;

  logic          push, pop, alu_acc, sel_valid;
  logic [4:0]    sel_rd;
  logic [63:0]   sel_data;
  logic [31:0]   set_mask, clr_mask;

  assign bus.lsu_ready = (count_q != FULL_CNT) & ~rst;
  // ALU is only accepted when no long result is waiting.
  assign bus.alu_ready = (count_q == '0) & ~rst;

  assign push    = bus.lsu_valid & bus.lsu_ready;
  // Pop depends on the registered count only, so a result pushed this
  // cycle cannot leave before the next one.
  assign pop     = (count_q != '0) & ~rst;
  assign alu_acc = bus.alu_valid & bus.alu_ready;

  always_comb begin
    sel_valid = pop | alu_acc;
    sel_rd    = bus.alu_rd;
    sel_data  = bus.alu_data;
    if (pop) begin
      sel_rd   = fifo_rd_q[rd_ptr_q];
      sel_data = fifo_data_q[rd_ptr_q];
    end

    // x0 results are consumed but never written; Rw/BusW keep old values.
    wen_d  = sel_valid & (sel_rd != 5'd0);
    rw_d   = wen_d ? sel_rd   : rw_q;
    busw_d = wen_d ? sel_data : busw_q;
    long_d = pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    set_mask = '0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) set_mask = 32'd1 << bus.iss_rd;
    // Clear on the edge the register file commits a long result.
    clr_mask = '0;
    if (wen_q && long_q) clr_mask = 32'd1 << rw_q;
    // Set after clear so a simultaneous set wins; bit 0 never set.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rw_q     <= '0;
      wen_q    <= 1'b0;
      busw_q   <= '0;
      long_q   <= 1'b0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rw_q     <= rw_d;
      wen_q    <= wen_d;
      busw_q   <= busw_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: validity is carried by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
      fifo_data_q[wr_ptr_q] <= bus.lsu_data;
    end
  end

  assign bus.Rw     = rw_q;
  assign bus.Wen    = wen_q;
  assign bus.BusW   = busw_q;
  assign bus.busy   = busy_q;
  assign bus.hazard = busy_q[bus.rs1] | busy_q[bus.rs2] | busy_q[bus.q_rd];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041412_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22041412_wbu
//  Purpose  : Self-checking bench for ysyx_22041412_wbu. A queue-based model
//             of the write-back unit is compared against the DUT every cycle;
//             directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041412_wbu;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22041412_wbu_if bus ();

  ysyx_22041412_wbu #(.LONG_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } res_t;

  // Model state: what the DUT's visible state must be in the current cycle.
  res_t        lq[$];
  logic        m_wen;
  logic        m_long;
  logic [4:0]  m_rw;
  logic [63:0] m_busw;
  logic [31:0] m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare + model advance at negedge; inputs are stable here and are the
  // values the DUT samples on the next posedge.
  initial begin : model
    res_t        e;
    bit          full, sel, popped;
    logic [4:0]  r;
    logic [63:0] d;
    int          clr;
    m_wen = 0; m_long = 0; m_rw = 0; m_busw = 0; m_busy = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("Wen", 64'(bus.Wen), 64'(m_wen));
        chk("Rw", 64'(bus.Rw), 64'(m_rw));
        chk("BusW", bus.BusW, m_busw);
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("alu_ready", 64'(bus.alu_ready), 64'(!rst && lq.size() == 0));
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(!rst && lq.size() < DEPTH));
        chk("hazard", 64'(bus.hazard),
            64'(m_busy[bus.rs1] | m_busy[bus.rs2] | m_busy[bus.q_rd]));
      end
      if (rst) begin
        lq.delete();
        m_wen = 0; m_long = 0; m_rw = 0; m_busw = 0; m_busy = 0;
      end else begin
        full   = (lq.size() >= DEPTH);
        clr    = (m_wen && m_long) ? int'(m_rw) : -1;
        sel    = 0;
        popped = 0;
        r      = 0;
        d      = 0;
        if (lq.size() > 0) begin
          e = lq.pop_front();
          r = e.rd; d = e.data; sel = 1; popped = 1;
        end else if (bus.alu_valid) begin
          r = bus.alu_rd; d = bus.alu_data; sel = 1;
        end
        if (bus.lsu_valid && !full) lq.push_back({bus.lsu_rd, bus.lsu_data});
        m_wen  = sel && (r != 0);
        m_long = popped;
        if (m_wen) begin
          m_rw   = r;
          m_busw = d;
        end
        if (clr > 0) m_busy[clr] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.alu_valid = 0; bus.lsu_valid = 0;
  endtask

  typedef struct {
    bit          iv;
    logic [4:0]  ir;
    bit          av;
    logic [4:0]  ar;
    logic [63:0] ad;
    bit          lv;
    logic [4:0]  lr;
    logic [63:0] ld;
    logic [4:0]  s1, s2, sq;
  } vec_t;

  vec_t tbl[10];

  initial begin : stim
    rst = 1'b1;
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.q_rd = 0;

    @(posedge clk);
    #1 chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);

    // First cycle out of reset
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("post_rst_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("post_rst_hazard", 64'(bus.hazard), 64'd0);
    chk("post_rst_Wen", 64'(bus.Wen), 64'd0);

    // ALU only
    step(); bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 64'h1234;
    @(negedge clk); chk("alu_ready_N", 64'(bus.alu_ready), 64'd1);
    step(); idle();
    @(negedge clk);
    chk("alu_Wen_N1", 64'(bus.Wen), 64'd1);
    chk("alu_Rw_N1", 64'(bus.Rw), 64'd5);
    chk("alu_BusW_N1", bus.BusW, 64'h1234);
    step();
    @(negedge clk);
    chk("alu_Wen_N2", 64'(bus.Wen), 64'd0);
    chk("alu_Rw_hold", 64'(bus.Rw), 64'd5);

    // Long op to x10
    step(); bus.iss_valid = 1; bus.iss_rd = 10;
    step(); idle(); bus.rs1 = 10;
    @(negedge clk);
    chk("long_busy10_set", 64'(bus.busy[10]), 64'd1);
    chk("long_hazard_set", 64'(bus.hazard), 64'd1);
    step();
    step(); bus.lsu_valid = 1; bus.lsu_rd = 10; bus.lsu_data = 64'hDEAD;
    @(negedge clk); chk("long_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    step(); idle();
    @(negedge clk); chk("long_alu_blocked", 64'(bus.alu_ready), 64'd0);
    step();
    @(negedge clk);
    chk("long_Wen_N5", 64'(bus.Wen), 64'd1);
    chk("long_Rw_N5", 64'(bus.Rw), 64'd10);
    chk("long_BusW_N5", bus.BusW, 64'hDEAD);
    chk("long_hazard_N5", 64'(bus.hazard), 64'd1);
    step();
    @(negedge clk);
    chk("long_busy10_clr", 64'(bus.busy[10]), 64'd0);
    chk("long_hazard_clr", 64'(bus.hazard), 64'd0);
    bus.rs1 = 0;

    // Contention: long result first, held ALU result next
    step(); bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 64'h33;
    step(); bus.lsu_valid = 0; bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 64'h44;
    @(negedge clk); chk("cont_alu_ready0", 64'(bus.alu_ready), 64'd0);
    step();
    @(negedge clk);
    chk("cont_alu_ready1", 64'(bus.alu_ready), 64'd1);
    chk("cont_Rw_long", 64'(bus.Rw), 64'd3);
    chk("cont_BusW_long", bus.BusW, 64'h33);
    step(); idle();
    @(negedge clk);
    chk("cont_Wen_alu", 64'(bus.Wen), 64'd1);
    chk("cont_Rw_alu", 64'(bus.Rw), 64'd4);
    chk("cont_BusW_alu", bus.BusW, 64'h44);

    // Back-to-back long results keep push order
    step(); bus.lsu_valid = 1; bus.lsu_rd = 11; bus.lsu_data = 64'hA1;
    step(); bus.lsu_rd = 12; bus.lsu_data = 64'hA2;
    step(); bus.lsu_rd = 13; bus.lsu_data = 64'hA3;
    @(negedge clk); chk("order_Rw0", 64'(bus.Rw), 64'd11);
    step(); idle();
    @(negedge clk); chk("order_Rw1", 64'(bus.Rw), 64'd12);
    step();
    @(negedge clk);
    chk("order_Rw2", 64'(bus.Rw), 64'd13);
    chk("order_BusW2", bus.BusW, 64'hA3);

    // x0 results and issues
    step(); bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 64'hFFFF;
    @(negedge clk); chk("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
    step(); idle(); bus.iss_valid = 1; bus.iss_rd = 0;
    @(negedge clk);
    chk("x0_Wen", 64'(bus.Wen), 64'd0);
    chk("x0_Rw_hold", 64'(bus.Rw), 64'd13);
    chk("x0_BusW_hold", bus.BusW, 64'hA3);
    step(); idle();
    @(negedge clk); chk("x0_busy", 64'(bus.busy), 64'd0);

    // Reset mid-flight
    step(); bus.iss_valid = 1; bus.iss_rd = 7;
    step(); idle(); bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 64'h77;
    step(); idle(); rst = 1'b1; bus.rs1 = 7;
    @(negedge clk);
    chk("mid_rst_busy7", 64'(bus.busy[7]), 64'd1);
    chk("mid_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_Wen", 64'(bus.Wen), 64'd0);
    chk("mid_rst_lsu_ready1", 64'(bus.lsu_ready), 64'd1);
    chk("mid_rst_hazard", 64'(bus.hazard), 64'd0);
    chk("mid_rst_Rw", 64'(bus.Rw), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk); chk("mid_rst_no_write", 64'(bus.Wen), 64'd0);
    end
    bus.rs1 = 0;

    // Mixed directed vectors, checked by the model
    tbl[0] = '{1, 20, 0, 0, 0,       0, 0, 0,         20, 0, 0};
    tbl[1] = '{1, 21, 0, 0, 0,       0, 0, 0,         0, 21, 0};
    tbl[2] = '{0, 0,  1, 22, 64'h22, 1, 20, 64'h2020, 0, 0, 21};
    tbl[3] = '{0, 0,  1, 23, 64'h23, 1, 21, 64'h2121, 20, 0, 0};
    tbl[4] = '{0, 0,  1, 23, 64'h23, 0, 0, 0,         0, 21, 0};
    tbl[5] = '{1, 24, 1, 23, 64'h23, 0, 0, 0,         0, 0, 24};
    tbl[6] = '{1, 25, 0, 0, 0,       1, 24, 64'h2424, 25, 0, 0};
    tbl[7] = '{0, 0,  1, 0, 64'h5,   1, 25, 64'h2525, 0, 0, 0};
    tbl[8] = '{0, 0,  0, 0, 0,       0, 0, 0,         24, 25, 0};
    tbl[9] = '{1, 26, 0, 0, 0,       0, 0, 0,         26, 0, 0};
    foreach (tbl[i]) begin
      step();
      bus.iss_valid = tbl[i].iv; bus.iss_rd   = tbl[i].ir;
      bus.alu_valid = tbl[i].av; bus.alu_rd   = tbl[i].ar; bus.alu_data = tbl[i].ad;
      bus.lsu_valid = tbl[i].lv; bus.lsu_rd   = tbl[i].lr; bus.lsu_data = tbl[i].ld;
      bus.rs1 = tbl[i].s1; bus.rs2 = tbl[i].s2; bus.q_rd = tbl[i].sq;
    end
    step(); idle(); bus.rs1 = 0; bus.rs2 = 0; bus.q_rd = 26;
    repeat (4) step();
    @(negedge clk);
    chk("tbl_busy_final", 64'(bus.busy), 64'h0400_0000);
    chk("tbl_hazard_final", 64'(bus.hazard), 64'd1);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
